// File: rtl/ulpi_rx_decoder_if.sv
// Bundle of the registered ULPI receive-side pad signals plus the decoded byte stream and RX CMD status.
// master = decoder side, slave = pad stage / link packet layer side.
interface ulpi_rx_decoder_if;
    logic       udir;
    logic       unxt;
    logic [7:0] udata_in;

    logic       rx_dv;
    logic [7:0] rx_data;
    logic       rx_last;
    logic       rx_err;

    logic       rxcmd_vld;
    logic [1:0] linestate;
    logic [1:0] vbus_state;
    logic       rx_active;
    logic       host_disc;
    logic       id_gnd;
    logic       alt_int;

    modport master (
        input  udir, unxt, udata_in,
        output rx_dv, rx_data, rx_last, rx_err,
        output rxcmd_vld, linestate, vbus_state, rx_active, host_disc, id_gnd, alt_int
    );

    modport slave (
        output udir, unxt, udata_in,
        input  rx_dv, rx_data, rx_last, rx_err,
        input  rxcmd_vld, linestate, vbus_state, rx_active, host_disc, id_gnd, alt_int
    );
endinterface

// File: rtl/ulpi_rx_decoder.sv
// Link-side ULPI receive decoder: separates RX CMD status from packet bytes and frames packets.
// Define ULPI_RX_STATS_EN to add the pkt_cnt / err_cnt statistics ports.
module ulpi_rx_decoder #(
    parameter int MAX_PKT = 1027,
    parameter int CNT_W   = 16
) (
    input  logic                  uclk,
    input  logic                  urst_n,
    ulpi_rx_decoder_if.master     bus
`ifdef ULPI_RX_STATS_EN
    ,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      err_cnt
`endif
);

    localparam int LEN_W = $clog2(MAX_PKT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TURN = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;

    // state holds the classification of the previous sample; cls classifies the current one
    logic [1:0]       state;
    logic [1:0]       cls;

    logic [7:0]       hold;
    logic             held;
    logic [LEN_W-1:0] len;
    logic             ovf;

    logic             dv_q;
    logic [7:0]       data_q;
    logic             last_q;
    logic             err_q;
    logic             cmd_q;
    logic [1:0]       ls_q;
    logic [1:0]       vb_q;
    logic             act_q;
    logic             hd_q;
    logic             id_q;
    logic             alt_q;

    logic             byte_in;
    logic             cmd_in;
    logic             cmd_err;
    logic             pkt_end;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cls = S_IDLE;
        if (bus.udir) begin
            cls = (state == S_IDLE) ? S_TURN : S_RECV;
        end
    end

    assign byte_in = (cls == S_RECV) &&  bus.unxt;
    assign cmd_in  = (cls == S_RECV) && !bus.unxt;
    assign cmd_err = cmd_in && bus.udata_in[5] && bus.udata_in[4];
    // RxActive (bit 4 alone) keeps the packet open; anything else, or the bus turning back, closes it
    assign pkt_end = (cmd_in && (!bus.udata_in[4] || bus.udata_in[5]))
                   || ((cls == S_IDLE) && (state != S_IDLE));

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge uclk or negedge urst_n) begin
        if (!urst_n) begin
            state  <= S_IDLE;
            hold   <= '0;
            held   <= 1'b0;
            len    <= '0;
            ovf    <= 1'b0;
            dv_q   <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
            cmd_q  <= 1'b0;
            ls_q   <= '0;
            vb_q   <= '0;
            act_q  <= 1'b0;
            hd_q   <= 1'b0;
            id_q   <= 1'b0;
            alt_q  <= 1'b0;
        end else begin
            state  <= cls;
            dv_q   <= 1'b0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
            cmd_q  <= 1'b0;

            if (byte_in) begin
                if (len == LEN_W'(MAX_PKT)) begin
                    ovf <= 1'b1;
                end else begin
                    len  <= len + LEN_W'(1);
                    hold <= bus.udata_in;
                    held <= 1'b1;
                    if (held) begin
                        dv_q   <= 1'b1;
                        data_q <= hold;
                    end
                end
            end

            if (pkt_end) begin
                if (held) begin
                    dv_q   <= 1'b1;
                    data_q <= hold;
                    last_q <= 1'b1;
                    err_q  <= cmd_err | ovf;
                end
                held <= 1'b0;
                len  <= '0;
                ovf  <= 1'b0;
            end

            if (cmd_in) begin
                cmd_q <= 1'b1;
                ls_q  <= bus.udata_in[1:0];
                vb_q  <= bus.udata_in[3:2];
                act_q <= bus.udata_in[4];
                hd_q  <= (bus.udata_in[5:4] == 2'b10);
                id_q  <= bus.udata_in[6];
                alt_q <= bus.udata_in[7];
            end

            // nxt during the turnaround means the PHY is already receiving
            if ((cls == S_TURN) && bus.unxt) begin
                cmd_q <= 1'b1;
                act_q <= 1'b1;
            end
        end
    end

    assign bus.rx_dv      = dv_q;
    assign bus.rx_data    = data_q;
    assign bus.rx_last    = last_q;
    assign bus.rx_err     = err_q;
    assign bus.rxcmd_vld  = cmd_q;
    assign bus.linestate  = ls_q;
    assign bus.vbus_state = vb_q;
    assign bus.rx_active  = act_q;
    assign bus.host_disc  = hd_q;
    assign bus.id_gnd     = id_q;
    assign bus.alt_int    = alt_q;

`ifdef ULPI_RX_STATS_EN
    always_ff @(posedge uclk or negedge urst_n) begin
        if (!urst_n) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (dv_q && last_q) begin
            pkt_cnt <= pkt_cnt + CNT_W'(1);
            if (err_q) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
